// File: rtl/cmp_pkg.sv
// Shared types and constants for the registered signed compare unit.
package cmp_pkg;

    localparam int CMP_WIDTH = 32;

    typedef logic [CMP_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t diff;
        logic  carry_out;
        logic  eq;
        logic  lt;
        logic  ltu;
    } cmp_result_t;

endpackage : cmp_pkg

// File: rtl/adder32b.sv
// 32-bit adder/subtractor: S = A + B, or A + ~B + 1 when SUB is set.
module adder32b
    import cmp_pkg::*;
(
    input  word_t A,
    input  word_t B,
    input  logic  SUB,
    output word_t S,
    output logic  COUT
);

    word_t              b_eff;
    logic [CMP_WIDTH:0] total;

    always_comb begin
        b_eff = B ^ {CMP_WIDTH{SUB}};
        total = {1'b0, A} + {1'b0, b_eff} + {{CMP_WIDTH{1'b0}}, SUB};
    end

    assign {COUT, S} = total;

endmodule : adder32b

// File: rtl/signed_compare_unit.sv
// Registered A-B compare (eq, signed lt, carry) with one-cycle latency.
// Optional unsigned less-than output is enabled by defining CMP_UNSIGNED_EN.
module signed_compare_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             carry_out,
    output logic             eq,
    output logic             lt
`ifdef CMP_UNSIGNED_EN
    ,
    output logic             ltu
`endif
);

    localparam int MSB = CMP_WIDTH - 1;

    word_t       sum;
    logic        cout;
    cmp_result_t res_d;
    logic        out_valid_d;

    logic        out_valid_q;
    word_t       diff_q;
    logic        carry_out_q;
    logic        eq_q;
    logic        lt_q;

    adder32b u_adder (
        .A    (a),
        .B    (b),
        .SUB  (1'b1),
        .S    (sum),
        .COUT (cout)
    );

    always_comb begin
        // NOTE: every field gets a default before use, so no latch can be inferred.
        res_d           = '0;
        res_d.diff      = sum;
        res_d.carry_out = cout;
        res_d.eq        = ~|sum;
        // Differing signs: A < B iff A is negative; equal signs cannot overflow.
        res_d.lt        = (a[MSB] & ~b[MSB]) | (~(a[MSB] ^ b[MSB]) & sum[MSB]);
        res_d.ltu       = ~cout;
        out_valid_d     = in_valid;
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            carry_out_q <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (in_valid) begin
                diff_q      <= res_d.diff;
                carry_out_q <= res_d.carry_out;
                eq_q        <= res_d.eq;
                lt_q        <= res_d.lt;
            end
        end
    end

`ifdef CMP_UNSIGNED_EN
    logic ltu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ltu_q <= 1'b0;
        end else if (in_valid) begin
            ltu_q <= res_d.ltu;
        end
    end

    assign ltu = ltu_q;
`else
    logic unused_ltu;
    assign unused_ltu = res_d.ltu;
`endif

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign carry_out = carry_out_q;
    assign eq        = eq_q;
    assign lt        = lt_q;

endmodule : signed_compare_unit

// File: tb/tb_signed_compare_unit.sv
// Self-checking bench for signed_compare_unit: directed vector table plus sequences.
module tb_signed_compare_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] diff;
    logic        carry_out;
    logic        eq;
    logic        lt;
`ifdef CMP_UNSIGNED_EN
    logic        ltu;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    signed_compare_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .diff      (diff),
        .carry_out (carry_out),
        .eq        (eq),
        .lt        (lt)
`ifdef CMP_UNSIGNED_EN
        ,
        .ltu       (ltu)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        carry;
        logic        eq;
        logic        lt;
        logic        ltu;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of operands, then sample #1 after the capturing edge.
    task automatic apply(input logic v, input logic [31:0] av, input logic [31:0] bv);
        in_valid = v;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_diff",      diff,           32'd0);
        check("reset_carry",     32'(carry_out), 32'd0);
        check("reset_eq",        32'(eq),        32'd0);
        check("reset_lt",        32'(lt),        32'd0);
`ifdef CMP_UNSIGNED_EN
        check("reset_ltu",       32'(ltu),       32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed extremes and carry/unsigned vectors.
        foreach (vecs[i]) begin
            apply(1'b1, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_diff", i),      diff,           vecs[i].diff);
            check($sformatf("vec%0d_carry", i),     32'(carry_out), 32'(vecs[i].carry));
            check($sformatf("vec%0d_eq", i),        32'(eq),        32'(vecs[i].eq));
            check($sformatf("vec%0d_lt", i),        32'(lt),        32'(vecs[i].lt));
`ifdef CMP_UNSIGNED_EN
            check($sformatf("vec%0d_ltu", i),       32'(ltu),       32'(vecs[i].ltu));
`endif
        end

        // Exhaustive sign-extended 8-bit sweep, back-to-back valid.
        for (int i = -128; i < 128; i++) begin
            for (int j = -128; j < 128; j++) begin
                logic [31:0] av;
                logic [31:0] bv;
                av = 32'(i);
                bv = 32'(j);
                apply(1'b1, av, bv);
                check("sweep_lt",        32'(lt),        32'(i < j));
                check("sweep_eq",        32'(eq),        32'(i == j));
                check("sweep_diff",      diff,           av - bv);
                check("sweep_out_valid", 32'(out_valid), 32'd1);
            end
        end

        // Hold: results persist while in_valid is low.
        apply(1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
        check("hold_load_lt",   32'(lt), 32'd1);
        check("hold_load_diff", diff,    32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, $urandom, $urandom);
            check("hold_out_valid", 32'(out_valid), 32'd0);
            check("hold_lt",        32'(lt),        32'd1);
            check("hold_diff",      diff,           32'hFFFF_FFFF);
        end

        // Asynchronous reset between edges, then normal sampling on the first edge.
        apply(1'b1, 32'd1, 32'd2);
        check("prereset_lt", 32'(lt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff",      diff,           32'd0);
        check("midrst_carry",     32'(carry_out), 32'd0);
        check("midrst_eq",        32'(eq),        32'd0);
        check("midrst_lt",        32'(lt),        32'd0);
`ifdef CMP_UNSIGNED_EN
        check("midrst_ltu",       32'(ltu),       32'd0);
`endif
        #1;
        rst_n = 1'b1;
        apply(1'b1, 32'd2, 32'd2);
        check("postrst_out_valid", 32'(out_valid), 32'd1);
        check("postrst_eq",        32'(eq),        32'd1);
        check("postrst_lt",        32'(lt),        32'd0);
        check("postrst_diff",      diff,           32'd0);

        // Back-to-back alternation of (-1,1) and (1,-1).
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) apply(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
            else            apply(1'b1, 32'h0000_0001, 32'hFFFF_FFFF);
            check("b2b_lt",        32'(lt),        32'((k % 2) == 0));
            check("b2b_out_valid", 32'(out_valid), 32'd1);
        end

        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_signed_compare_unit

// File: doc/signed_compare_unit.md
# signed_compare_unit

Registered 32-bit compare unit for the ALU datapath. It subtracts B from A with a 32-bit adder, detects equality from the zero result, and derives signed less-than from the sign bits of A, B and the difference. One result per cycle, one-cycle latency, with a valid qualifier. It feeds the SLT/branch-condition logic.

## Interface
Parameters
- WIDTH, 32, operand width; the design is only required at 32.

Ports
- clk, input, 1, rising-edge clock
- rst_n, input, 1, asynchronous active-low reset
- in_valid, input, 1, operands on a/b are valid this cycle
- a, input, 32, operand A (two's complement)
- b, input, 32, operand B (two's complement)
- out_valid, output, 1, registered results valid
- diff, output, 32, registered A − B (mod 2^32)
- carry_out, output, 1, registered adder carry-out of A + ~B + 1
- eq, output, 1, registered A == B
- lt, output, 1, registered signed A < B
- ltu, output, 1, registered unsigned A < B; present only with CMP_UNSIGNED_EN

## Operation
- Subtraction is computed as A + ~B + 1 in a 32-bit adder with SUB forced to 1. s is the 32-bit sum and cout is the carry.
- eq = (s == 0), using a 32-input NOR zero detect.
- lt = (a[31] & ~b[31]) | (~(a[31] ^ b[31]) & s[31]).
  - Signs differ: A < B exactly when A is negative.
  - Signs equal: the result is the sign of the difference.
  - Overflow cannot occur when signs are equal.
  - eq = 1 implies s[31] = 0, so lt = 0.
- ltu = ~cout, which is valid for unsigned operands.
- lt and eq are mutually exclusive.
- Results are registered only when in_valid = 1; otherwise diff, carry_out, eq, lt and ltu hold their previous values.
- out_valid is loaded with in_valid every cycle.
- There is no backpressure. Every valid input produces exactly one out_valid pulse one cycle later.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on the outputs after edge N. Throughput is 1 per cycle.
- Back-to-back valid inputs produce back-to-back valid outputs.
- Asserting rst_n = 0 asynchronously clears out_valid, diff, carry_out, eq, lt and ltu to 0.
- Reset mid-stream discards any in-flight result.
- The first edge after rst_n is released samples normally.
- All combinational logic (adder, zero detect, sign logic) must close timing within one clock period. No internal pipelining.

## Configuration
- CMP_UNSIGNED_EN
  - Defined: ltu port and register exist; ltu = ~cout is registered like lt.
  - Undefined: no ltu port and no ltu register. carry_out is still provided.

## Structure
- Shared package cmp_pkg holds:
  - CMP_WIDTH = 32
  - typedef word_t (logic [31:0])
  - a result struct {diff, carry_out, eq, lt, ltu}
- A single sub-module adder32b (ports A, B, SUB, S, COUT) implements the add/subtract. When SUB = 1 it inverts B and forces carry-in to 1.
- Zero detect and sign logic stay inline in the top module.

## Test plan
- Exhaustive sign-extended 8-bit sweep: every pair a, b in −128..127, with in_valid = 1 each cycle. One cycle later, require:
  - lt == ($signed(a) < $signed(b))
  - eq == (a == b)
  - diff == a − b
  - out_valid = 1
- Extremes, each pair one cycle:
  - a = 0x80000000, b = 0x7FFFFFFF → lt = 1, eq = 0, diff = 0x00000001
  - a = 0x7FFFFFFF, b = 0x80000000 → lt = 0
  - a = b = 0x80000000 → eq = 1, lt = 0, diff = 0
- Carry/unsigned:
  - a = 5, b = 3 → carry_out = 1, ltu = 0
  - a = 3, b = 5 → carry_out = 0, ltu = 1, lt = 1, diff = 0xFFFFFFFE
  - a = 0xFFFFFFFF, b = 1 → lt = 1, ltu = 0
- Hold: valid a = −1, b = 0, then 3 cycles with in_valid = 0 and random operands → out_valid = 0 and lt stays 1, diff stays 0xFFFFFFFF.
- Reset mid-operation: drive valid a = 1, b = 2, and pulse rst_n low between clock edges → all outputs 0 immediately. After release, the next valid a = 2, b = 2 gives eq = 1 one cycle later.
- Back-to-back: alternate (−1, 1) and (1, −1) for 10 consecutive valid cycles → lt alternates 1/0 with out_valid continuously 1.
